// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph table (active-high), the all-off
// pattern and a nibble-to-glyph lookup used by every display driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit order {g,f,e,d,c,b,a}; 1 = segment lit
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = ~hex_to_glyph(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver with tear-free updates,
// blanking, decimal points and leading-zero suppression. Optional macro
// SEG7_BRIGHTNESS_EN adds a 16-step per-slot brightness control.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   value_i,
  input  logic [N_DIGITS-1:0]     blank_mask_i,
  input  logic [N_DIGITS-1:0]     dp_in_i,
  input  logic                    lzs_i,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [3:0]              bright_i,
`endif
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_done_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic                    tick;
  logic                    wrap;

  logic [4*N_DIGITS-1:0]   pendValue_q, actValue_q;
  logic [N_DIGITS-1:0]     pendBlank_q, actBlank_q;
  logic [N_DIGITS-1:0]     pendDp_q, actDp_q;
  logic                    pendValid_q;

  logic [6:0]              seg_q, segD;
  logic                    dp_q, dpD;
  logic [N_DIGITS-1:0]     an_q, anD;
  logic                    frameDone_q;

  logic [3:0]              curNibble;
  logic                    curBlank, curDp, suppressed, dimmed, digitOff;
  logic [6:0]              glyphSeg;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frameDone_q <= 1'b0;
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + 1'b1;
      frameDone_q <= wrap;
      if (tick) idx_q <= wrap ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow registers: new content only reaches the display at a frame wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      pendValue_q <= '0;
      pendBlank_q <= '1;
      pendDp_q    <= '0;
      pendValid_q <= 1'b0;
      actValue_q  <= '0;
      actBlank_q  <= '1;
      actDp_q     <= '0;
    end else if (wrap && load_i) begin
      actValue_q  <= value_i;
      actBlank_q  <= blank_mask_i;
      actDp_q     <= dp_in_i;
      pendValid_q <= 1'b0;
    end else if (wrap && pendValid_q) begin
      actValue_q  <= pendValue_q;
      actBlank_q  <= pendBlank_q;
      actDp_q     <= pendDp_q;
      pendValid_q <= 1'b0;
    end else if (load_i) begin
      pendValue_q <= value_i;
      pendBlank_q <= blank_mask_i;
      pendDp_q    <= dp_in_i;
      pendValid_q <= 1'b1;
    end
  end

`ifdef SEG7_BRIGHTNESS_EN
  localparam int SUB_LEN = (CLK_DIV / 16 < 1) ? 1 : CLK_DIV / 16;
  localparam int SW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;

  logic [SW-1:0] subCnt_q;
  logic [3:0]    subIdx_q;
  logic [3:0]    bright_q;

  // Sub-slot 0 is always lit, so bright_i is used live only in that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      subCnt_q <= '0;
      subIdx_q <= '0;
      bright_q <= '0;
    end else begin
      if (cnt_q == '0) bright_q <= bright_i;
      if (tick) begin
        subCnt_q <= '0;
        subIdx_q <= '0;
      end else if (subCnt_q == SW'(SUB_LEN - 1)) begin
        subCnt_q <= '0;
        if (subIdx_q != 4'hF) subIdx_q <= subIdx_q + 4'd1;
      end else begin
        subCnt_q <= subCnt_q + 1'b1;
      end
    end
  end

  assign dimmed = (subIdx_q != 4'd0) && (subIdx_q > bright_q);
`else
  assign dimmed = 1'b0;
`endif

  // Walk from the most significant digit down so allZero covers digits >= i
  always_comb begin
    logic allZero;
    allZero    = 1'b1;
    curNibble  = 4'h0;
    curBlank   = 1'b1;
    curDp      = 1'b0;
    suppressed = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      allZero = allZero && (actValue_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        curNibble  = actValue_q[4*i +: 4];
        curBlank   = actBlank_q[i];
        curDp      = actDp_q[i];
        suppressed = lzs_i && (i != 0) && allZero;
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble_i (curNibble),
    .seg_o    (glyphSeg)
  );

  always_comb begin
    digitOff = curBlank || suppressed || dimmed;
    segD     = digitOff ? SEG_OFF : glyphSeg;
    dpD      = digitOff || !curDp;
    anD      = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      anD[i] = digitOff || (idx_q != IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= segD;
      dp_q  <= dpD;
      an_q  <= anD;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, CLK_DIV=4 (16-cycle frames).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blankMask;
  logic [3:0]  dpIn;
  logic        lzs;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frameDone;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]  bright = 4'hF;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .value_i      (value),
    .blank_mask_i (blankMask),
    .dp_in_i      (dpIn),
    .lzs_i        (lzs),
`ifdef SEG7_BRIGHTNESS_EN
    .bright_i     (bright),
`endif
    .seg_o        (seg),
    .dp_o         (dp),
    .an_o         (an),
    .frame_done_o (frameDone)
  );

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] m, input logic [3:0] d);
    value     = v;
    blankMask = m;
    dpIn      = d;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic waitFrame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frameDone === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the frame_done cycle; lead = cycles to the first digit-0 sample
  task automatic readSlots(input int lead, output logic [15:0] ans,
                           output logic [27:0] segs, output logic [3:0] dps);
    repeat (lead) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      ans[4*d +: 4]  = an;
      segs[7*d +: 7] = seg;
      dps[d]         = dp;
      if (d < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    load = 1'b0; value = 16'hBEEF; blankMask = 4'h0; dpIn = 4'hF; lzs = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (seg !== 7'h7F) $display("[TB] FAIL reset_seg: got %h want 7f", seg); else passCount++;
    checkCount++;
    if (an !== 4'hF) $display("[TB] FAIL reset_an: got %b want 1111", an); else passCount++;
    checkCount++;
    if (dp !== 1'b1) $display("[TB] FAIL reset_dp: got %b want 1", dp); else passCount++;
    checkCount++;
    if (frameDone !== 1'b0) $display("[TB] FAIL reset_frame_done: got %b want 0", frameDone); else passCount++;
  endtask

  task automatic test_idle_frames;
    int darkErrors = 0;
    logic [40:0] fdSeen = '0;
    logic [40:0] fdExp;
    fdExp = (41'd1 << 16) | (41'd1 << 32);
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (an !== 4'hF || seg !== 7'h7F) darkErrors++;
      fdSeen[i] = frameDone;
    end
    checkCount++;
    if (darkErrors !== 0) $display("[TB] FAIL idle_dark: got %0d lit cycles want 0", darkErrors); else passCount++;
    checkCount++;
    if (fdSeen !== fdExp) $display("[TB] FAIL idle_frame_done: got %h want %h", fdSeen, fdExp); else passCount++;
  endtask

  task automatic test_basic_display;
    bit ok;
    logic [15:0] ans; logic [27:0] segs; logic [3:0] dps;
    logic [3:0] expAn [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] expSeg [4] = '{7'h40, 7'h08, 7'h24, 7'h79};
    applyStimulus(16'h12A0, 4'h0, 4'h0);
    waitFrame(ok);
    checkCount++;
    if (ok !== 1'b1) $display("[TB] FAIL basic_frame_timeout: got %b want 1", ok); else passCount++;
    readSlots(2, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (ans[4*d +: 4] !== expAn[d]) $display("[TB] FAIL basic_an%0d: got %b want %b", d, ans[4*d +: 4], expAn[d]); else passCount++;
      checkCount++;
      if (segs[7*d +: 7] !== expSeg[d]) $display("[TB] FAIL basic_seg%0d: got %h want %h", d, segs[7*d +: 7], expSeg[d]); else passCount++;
    end
    checkCount++;
    if (dps !== 4'hF) $display("[TB] FAIL basic_dp: got %b want 1111", dps); else passCount++;
  endtask

  task automatic test_tear_free;
    bit ok;
    logic [15:0] ans; logic [27:0] segs; logic [3:0] dps;
    logic [6:0] oldSeg [4] = '{7'h40, 7'h08, 7'h24, 7'h79};
    waitFrame(ok);
    applyStimulus(16'hFFFF, 4'h0, 4'h0);
    readSlots(1, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (segs[7*d +: 7] !== oldSeg[d]) $display("[TB] FAIL tear_cur_seg%0d: got %h want %h", d, segs[7*d +: 7], oldSeg[d]); else passCount++;
    end
    waitFrame(ok);
    readSlots(2, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (segs[7*d +: 7] !== 7'h0E) $display("[TB] FAIL tear_next_seg%0d: got %h want 0e", d, segs[7*d +: 7]); else passCount++;
    end
  endtask

  task automatic test_mask_dp;
    bit ok;
    logic [15:0] ans; logic [27:0] segs; logic [3:0] dps;
    logic [3:0] expAn [4]  = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
    logic [6:0] expSeg [4] = '{7'h40, 7'h40, 7'h7F, 7'h40};
    applyStimulus(16'h0000, 4'b0100, 4'b0011);
    waitFrame(ok);
    readSlots(2, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (ans[4*d +: 4] !== expAn[d]) $display("[TB] FAIL mask_an%0d: got %b want %b", d, ans[4*d +: 4], expAn[d]); else passCount++;
      checkCount++;
      if (segs[7*d +: 7] !== expSeg[d]) $display("[TB] FAIL mask_seg%0d: got %h want %h", d, segs[7*d +: 7], expSeg[d]); else passCount++;
    end
    checkCount++;
    if (dps !== 4'b1100) $display("[TB] FAIL mask_dp: got %b want 1100", dps); else passCount++;
  endtask

  task automatic test_lzs;
    bit ok;
    logic [15:0] ans; logic [27:0] segs; logic [3:0] dps;
    logic [3:0] expAnA [4]  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [6:0] expSegA [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [3:0] expAnB [4]  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic [6:0] expSegB [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    lzs = 1'b1;
    applyStimulus(16'h0050, 4'h0, 4'h0);
    waitFrame(ok);
    readSlots(2, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (ans[4*d +: 4] !== expAnA[d]) $display("[TB] FAIL lzs50_an%0d: got %b want %b", d, ans[4*d +: 4], expAnA[d]); else passCount++;
      checkCount++;
      if (segs[7*d +: 7] !== expSegA[d]) $display("[TB] FAIL lzs50_seg%0d: got %h want %h", d, segs[7*d +: 7], expSegA[d]); else passCount++;
    end
    applyStimulus(16'h0000, 4'h0, 4'h0);
    waitFrame(ok);
    readSlots(2, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (ans[4*d +: 4] !== expAnB[d]) $display("[TB] FAIL lzs0_an%0d: got %b want %b", d, ans[4*d +: 4], expAnB[d]); else passCount++;
      checkCount++;
      if (segs[7*d +: 7] !== expSegB[d]) $display("[TB] FAIL lzs0_seg%0d: got %h want %h", d, segs[7*d +: 7], expSegB[d]); else passCount++;
    end
    lzs = 1'b0;
  endtask

  task automatic test_load_on_wrap;
    bit ok;
    logic [15:0] ans; logic [27:0] segs; logic [3:0] dps;
    logic [6:0] expSeg [4] = '{7'h79, 7'h24, 7'h19, 7'h00};
    waitFrame(ok);
    repeat (15) @(negedge clk);
    applyStimulus(16'h8421, 4'h0, 4'h0);
    checkCount++;
    if (frameDone !== 1'b1) $display("[TB] FAIL wrap_frame_done: got %b want 1", frameDone); else passCount++;
    readSlots(2, ans, segs, dps);
    for (int d = 0; d < 4; d++) begin
      checkCount++;
      if (segs[7*d +: 7] !== expSeg[d]) $display("[TB] FAIL wrap_seg%0d: got %h want %h", d, segs[7*d +: 7], expSeg[d]); else passCount++;
    end
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    int gap = 0;
    waitFrame(ok);
    repeat (9) @(negedge clk);
    checkCount++;
    if (an !== 4'b1011) $display("[TB] FAIL midscan_pre_an: got %b want 1011", an); else passCount++;
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frameDone !== 1'b0)
      $display("[TB] FAIL midscan_reset_outputs: got an=%b seg=%h dp=%b fd=%b want an=1111 seg=7f dp=1 fd=0",
               an, seg, dp, frameDone);
    else passCount++;
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frameDone === 1'b1) begin
        gap = i;
        break;
      end
    end
    checkCount++;
    if (gap !== 16) $display("[TB] FAIL midscan_restart_gap: got %0d want 16", gap); else passCount++;
    checkCount++;
    if (an !== 4'hF) $display("[TB] FAIL midscan_after_an: got %b want 1111", an); else passCount++;
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_basic_display();
    test_tear_free();
    test_mask_dp();
    test_lzs();
    test_load_on_wrap();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
